mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port, 64-bit-wide synchronous RAM between the instruction-fetch requester (IF) and the load/store requester (LSU).
- Each requester uses a valid/ready request handshake and gets a one-cycle response pulse.
- LSU has fixed priority over IF. A starvation counter forces an IF grant after STARVE_LIMIT consecutive LSU grants while IF is waiting.
- Sits between the core pipeline front/back ends and the memory model; it converts byte addresses to word indices.

Parameters:
PC_START, 64'h0000_0000_8000_0000, byte base address of RAM; subtracted before the word-index shift
STARVE_LIMIT, 4, max consecutive LSU grants while if_req_valid is high before IF is forced (range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
if_req_valid  in  1  IF fetch request
if_req_addr  in  64  IF byte address, 4-byte aligned
if_req_ready  out  1  IF request accepted this cycle
if_resp_valid  out  1  IF response pulse
if_resp_inst  out  32  fetched instruction
lsu_req_valid  in  1  LSU request
lsu_req_we  in  1  1 = write, 0 = read
lsu_req_addr  in  64  LSU byte address, 8-byte aligned
lsu_req_wdata  in  64  write data
lsu_req_wstrb  in  8  byte enables for write
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_resp_valid  out  1  LSU response pulse (read data or write ack)
lsu_resp_rdata  out  64  read data; 0 for write ack
ram_en  out  1  RAM read enable
ram_we  out  1  RAM write enable
ram_addr  out  64  word index = (addr - PC_START) >> 3
ram_wdata  out  64  write data
ram_wmask  out  64  bit mask; each wstrb bit expanded to 8 bits
ram_rdata  in  64  RAM read data, valid one cycle after ram_en

Behaviour:
- State machine: IDLE, IF_BUSY, LSU_BUSY. Reset → IDLE, starve_cnt = 0, latched sel_hi = 0.
- All outputs are 0 on reset and whenever no grant or response is active.
- IDLE grant selection, same cycle:
  - lsu_req_valid && !(if_req_valid && starve_cnt == STARVE_LIMIT) → grant LSU.
  - Else if_req_valid → grant IF.
  - Else stay in IDLE.
- Grant cycle:
  - The selected *_req_ready = 1; ram_en/ram_we/ram_addr/ram_wdata/ram_wmask are driven combinationally from the request.
  - ram_we = lsu_req_we for an LSU grant; 0 for an IF grant.
  - ram_en = 1 for reads only.
  - The non-selected ready = 0.
- Transitions: IF grant → IF_BUSY; latch if_req_addr[2] into sel_hi. LSU grant → LSU_BUSY; latch we.
- IF_BUSY (1 cycle):
  - if_resp_valid = 1; if_resp_inst = sel_hi ? ram_rdata[63:32] : ram_rdata[31:0].
  - No grants this cycle; ready outputs = 0. → IDLE.
- LSU_BUSY (1 cycle):
  - lsu_resp_valid = 1; lsu_resp_rdata = ram_rdata for a read, 0 for a write.
  - → IDLE.
- Latency and throughput: request accepted in cycle N, response in N+1, next grant earliest N+2. At most one outstanding request. Responses are not backpressurable.
- Starvation counter:
  - LSU grant while if_req_valid = 1 → starve_cnt++, saturating at STARVE_LIMIT.
  - Any IF grant → starve_cnt = 0.
  - LSU grant with if_req_valid = 0 → starve_cnt = 0.
- Requesters hold valid and payload stable until ready; the arbiter does not latch payload before the grant.
- Address arithmetic: 64-bit subtraction wraps modulo 2^64. Addresses below PC_START are not checked.
- Reset asserted mid-transaction: immediate return to IDLE; the pending response is dropped with no pulse. A write already issued is not retracted.
- No simultaneous responses: if_resp_valid and lsu_resp_valid are mutually exclusive.

Test Plan:
- IF only, if_req_addr = 0x8000_0004, RAM word 0 = 0xDEADBEEF_12345678 → ram_addr = 0 and ram_en = 1 in grant cycle; next cycle if_resp_valid = 1, if_resp_inst = 0xDEADBEEF.
- LSU write at addr 0x8000_0010, wstrb = 0x0F, wdata = 0x1122334455667788 → ram_addr = 2, ram_we = 1, ram_wmask = 0x00000000FFFFFFFF; next cycle lsu_resp_valid = 1, rdata = 0.
- IF and LSU both held valid continuously, STARVE_LIMIT = 4 → grant order LSU ×4, IF, LSU ×4, IF; each grant 2 cycles apart.
- Simultaneous requests with starve_cnt = 0 → LSU granted, if_req_ready = 0; IF granted at the next IDLE when LSU drops valid.
- rst pulsed during IF_BUSY → no if_resp_valid, all outputs 0, state IDLE, starve_cnt = 0; fresh LSU read after rst release completes normally.
- LSU read of word just written (0x8000_0010) → lsu_resp_rdata returns the masked-merged value, upper 32 bits unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port 64-bit synchronous RAM between instruction fetch and load/store.
// LSU has fixed priority; a starvation counter forces an IF grant after a run of LSU grants.
module mem_port_arbiter #(
  parameter logic [63:0] PC_START     = 64'h0000_0000_8000_0000,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  input  logic [63:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_inst,
  input  logic        lsu_req_valid,
  input  logic        lsu_req_we,
  input  logic [63:0] lsu_req_addr,
  input  logic [63:0] lsu_req_wdata,
  input  logic [7:0]  lsu_req_wstrb,
  output logic        lsu_req_ready,
  output logic        lsu_resp_valid,
  output logic [63:0] lsu_resp_rdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [63:0] ram_addr,
  output logic [63:0] ram_wdata,
  output logic [63:0] ram_wmask,
  input  logic [63:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, LSU_BUSY} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       sel_hi;
  logic       lsu_we_q;

  logic       grant_if;
  logic       grant_lsu;
  logic [63:0] wmask;

  // Grants are gated by rst so every output is quiet while reset is held.
  always_comb begin
    grant_lsu = !rst && (state == IDLE) && lsu_req_valid &&
                !(if_req_valid && (starve_cnt == LIMIT));
    grant_if  = !rst && (state == IDLE) && if_req_valid && !grant_lsu;
  end

  always_comb begin
    wmask = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      wmask[i*8 +: 8] = {8{lsu_req_wstrb[i]}};
    end
  end

  always_comb begin
    if_req_ready   = grant_if;
    lsu_req_ready  = grant_lsu;
    ram_en         = 1'b0;
    ram_we         = 1'b0;
    ram_addr       = '0;
    ram_wdata      = '0;
    ram_wmask      = '0;
    if (grant_if) begin
      ram_en   = 1'b1;
      ram_addr = (if_req_addr - PC_START) >> 3;
    end else if (grant_lsu) begin
      ram_en   = !lsu_req_we;
      ram_we   = lsu_req_we;
      ram_addr = (lsu_req_addr - PC_START) >> 3;
      if (lsu_req_we) begin
        ram_wdata = lsu_req_wdata;
        ram_wmask = wmask;
      end
    end
  end

  always_comb begin
    if_resp_valid  = (state == IF_BUSY);
    if_resp_inst   = '0;
    lsu_resp_valid = (state == LSU_BUSY);
    lsu_resp_rdata = '0;
    if (state == IF_BUSY) begin
      if_resp_inst = sel_hi ? ram_rdata[63:32] : ram_rdata[31:0];
    end
    if (state == LSU_BUSY && !lsu_we_q) begin
      lsu_resp_rdata = ram_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      sel_hi     <= 1'b0;
      lsu_we_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_lsu) begin
            state    <= LSU_BUSY;
            lsu_we_q <= lsu_req_we;
            if (if_req_valid) begin
              if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
            end else begin
              starve_cnt <= '0;
            end
          end else if (grant_if) begin
            state      <= IF_BUSY;
            sel_hi     <= if_req_addr[2];
            starve_cnt <= '0;
          end
        end
        IF_BUSY:  state <= IDLE;
        LSU_BUSY: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus hand-written arbitration and reset sequences,
// with responses checked against a scoreboard queue filled at grant time.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_valid;
  logic [63:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_inst;
  logic        lsu_req_valid;
  logic        lsu_req_we;
  logic [63:0] lsu_req_addr;
  logic [63:0] lsu_req_wdata;
  logic [7:0]  lsu_req_wstrb;
  logic        lsu_req_ready;
  logic        lsu_resp_valid;
  logic [63:0] lsu_resp_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [63:0] ram_addr;
  logic [63:0] ram_wdata;
  logic [63:0] ram_wmask;
  logic [63:0] ram_rdata;

  mem_port_arbiter #(.PC_START(64'h0000_0000_8000_0000), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_inst(if_resp_inst),
    .lsu_req_valid(lsu_req_valid), .lsu_req_we(lsu_req_we), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wmask(ram_wmask), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model, 16 words, indexed by the low bits of the word index.
  logic [63:0] mem [16];
  always @(posedge clk) begin
    if (ram_en) ram_rdata <= mem[ram_addr[3:0]];
    if (ram_we) mem[ram_addr[3:0]] <= (mem[ram_addr[3:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_lsu;
    logic [63:0] data;
  } resp_t;
  resp_t sb[$];

  always @(negedge clk) begin
    resp_t r;
    if (if_resp_valid || lsu_resp_valid) begin
      chk("resp_exclusive", 64'(if_resp_valid && lsu_resp_valid), 64'd0);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got if=%0b lsu=%0b expected none", if_resp_valid, lsu_resp_valid);
      end else begin
        r = sb.pop_front();
        chk("resp_port", 64'(lsu_resp_valid), 64'(r.is_lsu));
        chk("resp_data", lsu_resp_valid ? lsu_resp_rdata : {32'h0, if_resp_inst}, r.data);
      end
    end
  end

  typedef struct {
    logic        is_lsu;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        exp_en;
    logic        exp_we;
    logic [63:0] exp_addr;
    logic [63:0] exp_wmask;
    logic [63:0] exp_resp;
  } vec_t;
  vec_t vecs[11];

  task automatic chk_quiet(input string tag);
    chk({tag, "_if_ready"},   64'(if_req_ready),   64'd0);
    chk({tag, "_lsu_ready"},  64'(lsu_req_ready),  64'd0);
    chk({tag, "_if_resp"},    64'(if_resp_valid),  64'd0);
    chk({tag, "_lsu_resp"},   64'(lsu_resp_valid), 64'd0);
    chk({tag, "_inst"},       64'(if_resp_inst),   64'd0);
    chk({tag, "_rdata"},      lsu_resp_rdata,      64'd0);
    chk({tag, "_ram_en"},     64'(ram_en),         64'd0);
    chk({tag, "_ram_we"},     64'(ram_we),         64'd0);
    chk({tag, "_ram_addr"},   ram_addr,            64'd0);
    chk({tag, "_ram_wdata"},  ram_wdata,           64'd0);
    chk({tag, "_ram_wmask"},  ram_wmask,           64'd0);
  endtask

  task automatic apply(input vec_t v, input int idx);
    resp_t r;
    @(posedge clk); #1;
    if (v.is_lsu) begin
      lsu_req_valid = 1'b1;
      lsu_req_we    = v.we;
      lsu_req_addr  = v.addr;
      lsu_req_wdata = v.wdata;
      lsu_req_wstrb = v.wstrb;
    end else begin
      if_req_valid = 1'b1;
      if_req_addr  = v.addr;
    end
    @(negedge clk);
    chk($sformatf("v%0d_if_ready", idx),  64'(if_req_ready),  64'(!v.is_lsu));
    chk($sformatf("v%0d_lsu_ready", idx), 64'(lsu_req_ready), 64'(v.is_lsu));
    chk($sformatf("v%0d_ram_en", idx),    64'(ram_en),        64'(v.exp_en));
    chk($sformatf("v%0d_ram_we", idx),    64'(ram_we),        64'(v.exp_we));
    chk($sformatf("v%0d_ram_addr", idx),  ram_addr,           v.exp_addr);
    if (v.we) begin
      chk($sformatf("v%0d_ram_wmask", idx), ram_wmask, v.exp_wmask);
      chk($sformatf("v%0d_ram_wdata", idx), ram_wdata, v.wdata);
    end
    r.is_lsu = v.is_lsu;
    r.data   = v.exp_resp;
    sb.push_back(r);
    @(posedge clk); #1;
    if_req_valid  = 1'b0;
    lsu_req_valid = 1'b0;
  endtask

  logic exp_lsu_order [10];
  int   ng;
  int   last_c;

  initial begin
    resp_t r;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0]  = 64'hDEAD_BEEF_1234_5678;
    mem[2]  = 64'hAAAA_BBBB_CCCC_DDDD;
    mem[15] = 64'h0123_4567_89AB_CDEF;
    ram_rdata = '0;

    //            lsu   we    addr                    wdata                   wstrb  en    we    ram_addr                 wmask                   resp
    vecs[0]  = '{1'b0, 1'b0, 64'h8000_0004,          64'h0,                  8'h00, 1'b1, 1'b0, 64'd0,                   64'h0,                  64'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 1'b0, 64'h8000_0000,          64'h0,                  8'h00, 1'b1, 1'b0, 64'd0,                   64'h0,                  64'h1234_5678};
    vecs[2]  = '{1'b1, 1'b1, 64'h8000_0010,          64'h1122_3344_5566_7788, 8'h0F, 1'b0, 1'b1, 64'd2,                   64'h0000_0000_FFFF_FFFF, 64'h0};
    vecs[3]  = '{1'b1, 1'b0, 64'h8000_0010,          64'h0,                  8'h00, 1'b1, 1'b0, 64'd2,                   64'h0,                  64'hAAAA_BBBB_5566_7788};
    vecs[4]  = '{1'b1, 1'b1, 64'h8000_0018,          64'hFFFF_FFFF_FFFF_FFFF, 8'hA5, 1'b0, 1'b1, 64'd3,                   64'hFF00_FF00_00FF_00FF, 64'h0};
    vecs[5]  = '{1'b1, 1'b0, 64'h8000_0018,          64'h0,                  8'h00, 1'b1, 1'b0, 64'd3,                   64'h0,                  64'hFF00_FF00_00FF_00FF};
    vecs[6]  = '{1'b0, 1'b0, 64'h8000_001C,          64'h0,                  8'h00, 1'b1, 1'b0, 64'd3,                   64'h0,                  64'hFF00_FF00};
    vecs[7]  = '{1'b0, 1'b0, 64'h8000_0018,          64'h0,                  8'h00, 1'b1, 1'b0, 64'd3,                   64'h0,                  64'h00FF_00FF};
    vecs[8]  = '{1'b1, 1'b0, 64'h7FFF_FFF8,          64'h0,                  8'h00, 1'b1, 1'b0, 64'h1FFF_FFFF_FFFF_FFFF, 64'h0,                  64'h0123_4567_89AB_CDEF};
    vecs[9]  = '{1'b1, 1'b1, 64'h8000_0000,          64'hABCD_EF01_2345_6789, 8'h80, 1'b0, 1'b1, 64'd0,                   64'hFF00_0000_0000_0000, 64'h0};
    vecs[10] = '{1'b1, 1'b0, 64'h8000_0000,          64'h0,                  8'h00, 1'b1, 1'b0, 64'd0,                   64'h0,                  64'hABAD_BEEF_1234_5678};

    exp_lsu_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    if_req_valid = 1'b0; if_req_addr = '0;
    lsu_req_valid = 1'b0; lsu_req_we = 1'b0; lsu_req_addr = '0;
    lsu_req_wdata = '0; lsu_req_wstrb = '0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) apply(vecs[i], i);

    // Both requesters held valid: expect LSU x4, IF, LSU x4, IF, two cycles apart.
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0000;
    lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_addr = 64'h8000_0010;
    ng = 0;
    last_c = -1;
    for (int c = 0; c < 60 && ng < 10; c++) begin
      @(negedge clk);
      if (if_req_ready || lsu_req_ready) begin
        chk("starve_excl", 64'(if_req_ready && lsu_req_ready), 64'd0);
        chk($sformatf("starve_grant%0d", ng), 64'(lsu_req_ready), 64'(exp_lsu_order[ng]));
        if (ng > 0) chk($sformatf("starve_gap%0d", ng), 64'(c - last_c), 64'd2);
        r.is_lsu = lsu_req_ready;
        r.data   = lsu_req_ready ? 64'hAAAA_BBBB_5566_7788 : 64'h1234_5678;
        sb.push_back(r);
        last_c = c;
        ng++;
      end
    end
    chk("starve_grant_count", 64'(ng), 64'd10);
    @(posedge clk); #1;
    if_req_valid = 1'b0; lsu_req_valid = 1'b0;

    // Simultaneous requests with a cleared counter: LSU first, IF once LSU drops.
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0004;
    lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_addr = 64'h8000_0000;
    @(negedge clk);
    chk("simul_lsu_ready", 64'(lsu_req_ready), 64'd1);
    chk("simul_if_ready0", 64'(if_req_ready), 64'd0);
    r.is_lsu = 1'b1; r.data = 64'hABAD_BEEF_1234_5678; sb.push_back(r);
    @(posedge clk); #1;
    lsu_req_valid = 1'b0;
    @(negedge clk);
    chk("simul_busy_if_ready", 64'(if_req_ready), 64'd0);
    @(negedge clk);
    chk("simul_if_ready1", 64'(if_req_ready), 64'd1);
    chk("simul_if_ram_addr", ram_addr, 64'd0);
    r.is_lsu = 1'b0; r.data = 64'hABAD_BEEF; sb.push_back(r);
    @(posedge clk); #1;
    if_req_valid = 1'b0;

    // Reset during IF_BUSY drops the response; requests seen during reset are ignored.
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0004;
    @(negedge clk);
    chk("rstseq_if_ready", 64'(if_req_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_addr = 64'h8000_0000;
    @(negedge clk);
    chk_quiet("rstseq");
    @(posedge clk); #1;
    rst = 1'b0;
    if_req_valid = 1'b0; lsu_req_valid = 1'b0;
    apply(vecs[10], 11);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
